// File: rtl/master_tx.sv
// master_tx: burst traffic generator emitting an incrementing data pattern.
// Latency: first beat valid one cycle after an accepted start; done one cycle after the final beat.
// Backpressure: valid/data hold until ready; valid never depends combinationally on ready.
//
// Ports:
//   clk, rst_n        - single rising-edge clock, asynchronous active-low reset
//   start             - one-cycle transfer request, honoured only while idle
//   seed              - first data value of the transfer (sampled with start)
//   burst_len         - beats per burst, 0 encodes 2^LEN_W (sampled with start)
//   num_bursts        - bursts per transfer, 0 encodes 2^LEN_W (sampled with start)
//   gap_len           - idle cycles between bursts, 0 means none (sampled with start)
//   ready             - sink acceptance; a beat moves on valid && ready
//   valid, data       - registered beat presentation
//   busy              - high whenever the block is not idle
//   done              - one-cycle pulse after the last beat is accepted
//   stall_cnt         - present only with MASTER_TX_STALL_CNT_EN: saturating count of
//                       valid && !ready cycles, cleared on reset and accepted start
module master_tx #(
  parameter int DATA_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [LEN_W-1:0]  num_bursts,
  input  logic [LEN_W-1:0]  gap_len,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done
`ifdef MASTER_TX_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [LEN_W:0]    CNT_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W-1:0]  GAP_ONE  = LEN_W'(1);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);
  // A zero length field stands for the full 2^LEN_W count.
  localparam logic [LEN_W:0]    LEN_MAX  = {1'b1, {LEN_W{1'b0}}};

  state_t            state, state_nxt;
  logic              valid_nxt, busy_nxt, done_nxt;
  logic [DATA_W-1:0] data_nxt;

  // Counters are one bit wider than the length fields so 2^LEN_W is exact.
  logic [LEN_W:0]    beat_cnt, beat_nxt;
  logic [LEN_W:0]    burst_cnt, burst_nxt;
  logic [LEN_W-1:0]  gap_cnt, gap_cnt_nxt;

  logic [LEN_W:0]    blen_q, blen_nxt;
  logic [LEN_W:0]    nbur_q, nbur_nxt;
  logic [LEN_W-1:0]  gap_q, gap_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= 1'b0;
      data      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      blen_q    <= '0;
      nbur_q    <= '0;
      gap_q     <= '0;
    end else begin
      state     <= state_nxt;
      valid     <= valid_nxt;
      data      <= data_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      beat_cnt  <= beat_nxt;
      burst_cnt <= burst_nxt;
      gap_cnt   <= gap_cnt_nxt;
      blen_q    <= blen_nxt;
      nbur_q    <= nbur_nxt;
      gap_q     <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    valid_nxt   = valid;
    data_nxt    = data;
    done_nxt    = 1'b0;
    beat_nxt    = beat_cnt;
    burst_nxt   = burst_cnt;
    gap_cnt_nxt = gap_cnt;
    blen_nxt    = blen_q;
    nbur_nxt    = nbur_q;
    gap_nxt     = gap_q;

    case (state)
      IDLE: begin
        if (start) begin
          blen_nxt    = (burst_len == '0)  ? LEN_MAX : {1'b0, burst_len};
          nbur_nxt    = (num_bursts == '0) ? LEN_MAX : {1'b0, num_bursts};
          gap_nxt     = gap_len;
          beat_nxt    = '0;
          burst_nxt   = '0;
          gap_cnt_nxt = '0;
          data_nxt    = seed;
          valid_nxt   = 1'b1;
          state_nxt   = SEND;
        end
      end

      SEND: begin
        if (valid && ready) begin
          // The pattern keeps counting across burst boundaries.
          data_nxt = data + DATA_ONE;
          if (beat_cnt + CNT_ONE == blen_q) begin
            beat_nxt = '0;
            if (burst_cnt + CNT_ONE == nbur_q) begin
              burst_nxt = '0;
              valid_nxt = 1'b0;
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              burst_nxt = burst_cnt + CNT_ONE;
              if (gap_q != '0) begin
                valid_nxt   = 1'b0;
                gap_cnt_nxt = '0;
                state_nxt   = GAP;
              end
            end
          end else begin
            beat_nxt = beat_cnt + CNT_ONE;
          end
        end
      end

      GAP: begin
        // valid is low for exactly gap_q cycles, then the next burst starts.
        if (gap_cnt + GAP_ONE == gap_q) begin
          gap_cnt_nxt = '0;
          valid_nxt   = 1'b1;
          state_nxt   = SEND;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_ONE;
        end
      end

      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

`ifdef MASTER_TX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (valid && !ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_master_tx.sv
// tb_master_tx: randomized scoreboard bench for master_tx.
// Latency: expectations queued at start issue, consumed by a negedge monitor on each handshake.
// Backpressure: sink drives ready as always-on, random, or burst-then-stall patterns.
module tb_master_tx;

  localparam int DATA_W = 4;
  localparam int LEN_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] seed;
  logic [LEN_W-1:0]  burst_len;
  logic [LEN_W-1:0]  num_bursts;
  logic [LEN_W-1:0]  gap_len;
  logic              ready;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;
`ifdef MASTER_TX_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  master_tx #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .burst_len  (burst_len),
    .num_bursts (num_bursts),
    .gap_len    (gap_len),
    .ready      (ready),
    .valid      (valid),
    .data       (data),
    .busy       (busy),
    .done       (done)
`ifdef MASTER_TX_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    int data;
    int gap;   // valid-low busy cycles expected right before this beat
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    checks    = 0;
  int    failures  = 0;
  int    hs_total  = 0;
  int    exp_stall = 0;
  int    ready_mode = 0;  // 0: always ready, 1: random, 2: ten beats then a 5-10 cycle stall

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the full beat list of a transfer from the length rules alone.
  task automatic model_transfer(input int s, input int bl, input int nb, input int gl);
    int bl_n, nb_n, idx;
    beat_t b;
    bl_n = (bl == 0) ? (1 << LEN_W) : bl;
    nb_n = (nb == 0) ? (1 << LEN_W) : nb;
    idx  = 0;
    for (int i = 0; i < nb_n; i++) begin
      for (int k = 0; k < bl_n; k++) begin
        b.data = (s + idx) % (1 << DATA_W);
        b.gap  = (i > 0 && k == 0) ? gl : 0;
        b.last = (i == nb_n - 1) && (k == bl_n - 1);
        exp_q.push_back(b);
        idx++;
      end
    end
  endtask

  // Called just after a rising edge; returns just after the edge that samples start.
  task automatic issue_start(input int s, input int bl, input int nb, input int gl, input bit accepted);
    seed       = DATA_W'(s);
    burst_len  = LEN_W'(bl);
    num_bursts = LEN_W'(nb);
    gap_len    = LEN_W'(gl);
    if (accepted) begin
      model_transfer(s, bl, nb, gl);
      exp_stall = 0;
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done_within_3000_cycles", name);
    end
  endtask

  // Sink: drives ready just after each rising edge.
  initial begin : sink
    int stall_left;
    int hs_mark;
    stall_left = 0;
    hs_mark    = 0;
    ready      = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (stall_left == 0 && hs_total - hs_mark >= 10) begin
            stall_left = $urandom_range(5, 10);
            hs_mark    = hs_total;
          end
          if (stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
          end else begin
            ready = 1'b1;
          end
        end
        default: begin
          ready      = 1'b1;
          stall_left = 0;
          hs_mark    = hs_total;
        end
      endcase
    end
  end

  // Monitor: compares every handshake against the queued model on the falling edge.
  bit                exp_done   = 1'b0;
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  int                idle_run   = 0;

  always @(negedge clk) begin : monitor
    beat_t b;
    if (!rst_n) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
      idle_run   = 0;
    end else begin
      chk("done_pulse", done, exp_done);
      if (done) begin
        chk("busy_at_done", busy, 0);
`ifdef MASTER_TX_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, exp_stall);
`endif
      end
      exp_done = 1'b0;
      if (prev_stall) begin
        chk("stall_hold_valid", valid, 1);
        chk("stall_hold_data", data, prev_data);
      end
      if (valid) chk("busy_with_valid", busy, 1);
      if (valid && !ready && exp_stall < 16'hFFFF) exp_stall++;
      if (valid && ready) begin
        hs_total++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h expected=no_beat at %0t", data, $time);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", data, b.data);
          chk("gap_cycles", idle_run, b.gap);
          exp_done = b.last;
        end
        idle_run = 0;
      end else if (busy && !valid) begin
        idle_run++;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
    end
  end

  initial begin : stimulus
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    seed       = '0;
    burst_len  = '0;
    num_bursts = '0;
    gap_len    = '0;
    #2;
    chk("reset_valid", valid, 0);
    chk("reset_data", data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
`ifdef MASTER_TX_STALL_CNT_EN
    chk("reset_stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst, then a wrapping burst issued in the same cycle done is high.
    ready_mode = 0;
    issue_start(3, 4, 1, 0, 1);
    wait_done("basic");
    issue_start(14, 4, 1, 0, 1);
    wait_done("wrap");

    // Two bursts separated by a two-cycle gap.
    issue_start($urandom_range(0, 15), 3, 2, 2, 1);
    wait_done("gap");

    // num_bursts=0 encodes 16 single-beat bursts.
    issue_start($urandom_range(0, 15), 1, 0, 0, 1);
    wait_done("max_bursts");

    // Full-length bursts with periodic sink stalls.
    ready_mode = 2;
    issue_start($urandom_range(0, 15), 0, 2, 0, 1);
    wait_done("stall");

    // A start while busy must be ignored.
    ready_mode = 0;
    issue_start(5, 8, 2, 1, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    issue_start(9, 2, 1, 0, 0);
    wait_done("ignore_start");

    // Reset in the middle of a burst: everything clears at once, no done.
    issue_start(7, 6, 1, 0, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", valid, 0);
    chk("midreset_data", data, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    exp_q.delete();
    exp_stall = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    chk("idle_after_reset", busy, 0);
    issue_start(2, 5, 2, 1, 1);
    wait_done("after_reset");

    // Random transfers against a random sink.
    ready_mode = 1;
    for (int t = 0; t < 12; t++) begin
      issue_start($urandom_range(0, 15), $urandom_range(0, 5),
                  $urandom_range(1, 3), $urandom_range(0, 3), 1);
      wait_done("random");
    end

    ready_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
